mod_n_counter: RTL and testbench
================================

// Module: mod_n_counter
// PURPOSE
//   Free-running modulo-N up-counter: 0,1,...,N-1,0,... advancing one step per rising clk edge.
//   Generic building block for dividers and sequence counters; the clk input may be a
//   derived/gated clock, and cascades are built by feeding one counter's terminal condition
//   into another counter's clk.
// PARAMETERS (positional order is fixed: N first, then WIDTH)
//   N      6   modulus; count range 0..N-1; legal N >= 2
//   WIDTH  3   bit width of out; legal when N <= 2**WIDTH
// PORTS
//   clk          input   1      count clock, rising-edge active; may be a gated/derived signal
//   GlobalReset  input   1      asynchronous, active-high reset
//   out          output  WIDTH  current count value, registered
//   tc           output  1      terminal count: 1 while out == N-1 (combinational decode of out)
// BEHAVIOUR
//   - One clock (clk), one async active-high reset (GlobalReset).
//   - Reset: GlobalReset=1 forces out=0 immediately, without waiting for clk. out holds 0
//     for as long as reset is high; clk edges are ignored during reset. tc=0 during reset (N>=2).
//   - Count: on each rising clk edge with GlobalReset=0:
//       out <= (out == N-1) ? 0 : out + 1.
//     Latency: out changes one edge after the condition; no enable input, every edge counts.
//   - Wrap: N-1 -> 0 always, including when N is not a power of two (e.g. N=6: 5 -> 0, never 6 or 7).
//     For N == 2**WIDTH the wrap equals natural overflow; same compare logic used.
//   - Out-of-range state (out >= N, only reachable via upset): next edge loads 0.
//   - Reset mid-count: asserting reset at any value returns out to 0 asynchronously; first edge
//     after release gives out=1.
//   - Reset release coincident with a clk edge: that edge is not counted (out stays 0); the
//     system must not rely on it.
//   - Stalled clk (held high or low): out holds its value indefinitely.
//   - out is glitch-free (direct flop outputs) so it may drive logic that forms another
//     counter's clk; tc is decoded and is only glitch-free when used synchronously.
//   - Elaboration check: N < 2 or N > 2**WIDTH is a fatal parameter error
//     ($error/$fatal in a generate block).
// STRUCTURE
//   - Single module, no sub-modules; one WIDTH-bit register with async reset, next-state mux,
//     terminal-count compare, parameter-legality generate block.
//   - No shared package needed; localparam LAST = N-1 (sized to WIDTH) stays local.
//   - Optional: the tc output may be left unconnected by instantiators.
// TESTING
//   1. Reset: GlobalReset=1 with clk toggling -> out=0, tc=0 throughout. Assert reset between
//      edges -> out goes to 0 before the next edge.
//   2. N=6, WIDTH=3: release reset, 12 edges -> out = 1,2,3,4,5,0,1,2,3,4,5,0;
//      tc=1 exactly while out=5.
//   3. N=2, WIDTH=1: 4 edges -> out toggles 1,0,1,0.
//   4. Cascade/freeze: A = mod_n_counter #(6,3), B = #(2,1). A.clk = clk | B.out,
//      B.clk = (A.out==5) | B.out. After reset and 5 clk periods: A.out=5, B.out=1.
//      Then both freeze at A.out=5, B.out=1 for 30+ further clk periods.
//   5. Reset mid-operation: at A.out=3 pulse GlobalReset for half a period -> out=0 at once;
//      next edges give 1,2,...
//   6. Power-of-two modulus N=8, WIDTH=3: 8 edges from 0 -> returns to 0 (7 -> 0).
//      Illegal N=9, WIDTH=3 -> elaboration error.

Source files
------------

// File: rtl/mod_n_counter_pkg.sv
// Shared helpers for the modulo-N counter family.
//   modulus_legal(n, width) : 1 when a counter of modulus n fits in width bits
//                             (n >= 2 and n <= 2**width).
package mod_n_counter_pkg;

  function automatic bit modulus_legal(input int n, input int width);
    if (width < 1 || width > 31) return 1'b0;
    return (n >= 2) && (longint'(n) <= (longint'(1) << width));
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Free-running modulo-N up-counter: 0,1,...,N-1,0,... one step per rising clk edge.
// clk may be a derived or gated clock. Counters are cascaded by feeding one
// counter's terminal condition into the next counter's clk.
// Parameters (positional order fixed):
//   N     : modulus, count range 0..N-1, legal N >= 2
//   WIDTH : width of out, legal when N <= 2**WIDTH
// Ports:
//   clk         : count clock, rising-edge active
//   GlobalReset : asynchronous active-high reset, forces out to 0
//   out         : current count, direct flop outputs (glitch-free)
//   tc          : terminal count, combinational decode of out == N-1
module mod_n_counter
  import mod_n_counter_pkg::*;
#(
  parameter int N     = 6,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             GlobalReset,
  output logic [WIDTH-1:0] out,
  output logic             tc
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

  generate
    if (!modulus_legal(N, WIDTH)) begin : g_illegal_params
      $error("mod_n_counter: illegal parameters N=%0d WIDTH=%0d (need 2 <= N <= 2**WIDTH)",
             N, WIDTH);
    end
  endgenerate

  logic [WIDTH-1:0] next_count;

  // The >= compare wraps at N-1 and also recovers any upset state above N-1.
  always_comb begin
    next_count = out + WIDTH'(1);
    if (out >= LAST) next_count = '0;
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) out <= '0;
    else             out <= next_count;
  end

  assign tc = (out == LAST);

endmodule

// File: tb/tb_mod_n_counter.sv
module tb_mod_n_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] out6, out8, a_out;
  logic [0:0] out2, b_out;
  logic       tc6, tc2, tc8, a_tc, b_tc;
  logic       a_clk, b_clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [2:0] q6[$];
  logic [2:0] q2[$];
  logic [2:0] q8[$];
  logic [2:0] qa[$];
  logic [2:0] qb[$];

  always #5 clk = ~clk;

  assign a_clk = clk | b_out[0];
  assign b_clk = (a_out == 3'd5) | b_out[0];

  mod_n_counter #(.N(6), .WIDTH(3)) dut6 (.clk(clk), .GlobalReset(rst), .out(out6), .tc(tc6));
  mod_n_counter #(.N(2), .WIDTH(1)) dut2 (.clk(clk), .GlobalReset(rst), .out(out2), .tc(tc2));
  mod_n_counter #(.N(8), .WIDTH(3)) dut8 (.clk(clk), .GlobalReset(rst), .out(out8), .tc(tc8));
  mod_n_counter #(.N(6), .WIDTH(3)) cnt_a (.clk(a_clk), .GlobalReset(rst), .out(a_out), .tc(a_tc));
  mod_n_counter #(.N(2), .WIDTH(1)) cnt_b (.clk(b_clk), .GlobalReset(rst), .out(b_out), .tc(b_tc));

  // Pulse reset between edges; release lands 3 time units before the next posedge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      total_cnt++;
      if ({out6, out8, a_out, out2, b_out} !== 11'd0) begin
        $display("FAIL reset_hold edge %0d: out6=%0d out2=%0d out8=%0d a=%0d b=%0d, required all 0",
                 i, out6, out2, out8, a_out, b_out);
      end else pass_cnt++;
      total_cnt++;
      if ({tc6, tc2, tc8} !== 3'b000) begin
        $display("FAIL reset_tc edge %0d: tc6=%b tc2=%b tc8=%b, required 000", i, tc6, tc2, tc8);
      end else pass_cnt++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (out6 !== 3'd2) $display("FAIL reset_precount: out6=%0d required 2", out6);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (out6 !== 3'd0 || out8 !== 3'd0 || tc6 !== 1'b0) begin
      $display("FAIL reset_async: out6=%0d out8=%0d tc6=%b, required 0 0 0 before next edge",
               out6, out8, tc6);
    end else pass_cnt++;
    #1;
    rst = 1'b0;
  endtask

  task automatic test_count_n6();
    logic [2:0] seq [12] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    logic [2:0] exp;
    do_reset();
    foreach (seq[i]) q6.push_back(seq[i]);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      exp = q6.pop_front();
      total_cnt++;
      if (out6 !== exp) $display("FAIL n6_count edge %0d: out=%0d required %0d", i, out6, exp);
      else pass_cnt++;
      total_cnt++;
      if (tc6 !== (exp == 3'd5)) $display("FAIL n6_tc edge %0d: tc=%b required %b", i, tc6, exp == 3'd5);
      else pass_cnt++;
    end
  endtask

  task automatic test_count_n2();
    logic [2:0] exp;
    do_reset();
    q2.push_back(3'd1); q2.push_back(3'd0); q2.push_back(3'd1); q2.push_back(3'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      exp = q2.pop_front();
      total_cnt++;
      if (out2 !== exp[0:0] || tc2 !== exp[0]) begin
        $display("FAIL n2_toggle edge %0d: out=%b tc=%b required out=%b tc=%b", i, out2, tc2, exp[0], exp[0]);
      end else pass_cnt++;
    end
  endtask

  task automatic test_count_n8();
    logic [2:0] exp;
    do_reset();
    for (int i = 1; i <= 8; i++) q8.push_back(3'(i % 8));
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      exp = q8.pop_front();
      total_cnt++;
      if (out8 !== exp || tc8 !== (exp == 3'd7)) begin
        $display("FAIL n8_count edge %0d: out=%0d tc=%b required out=%0d tc=%b",
                 i, out8, tc8, exp, exp == 3'd7);
      end else pass_cnt++;
    end
  endtask

  task automatic test_cascade_freeze();
    logic [2:0] ea, eb;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      qa.push_back(3'(i));
      qb.push_back((i == 5) ? 3'd1 : 3'd0);
    end
    for (int i = 0; i < 32; i++) begin
      qa.push_back(3'd5);
      qb.push_back(3'd1);
    end
    for (int i = 0; i < 37; i++) begin
      @(posedge clk);
      #1;
      ea = qa.pop_front();
      eb = qb.pop_front();
      total_cnt++;
      if (a_out !== ea || b_out !== eb[0:0]) begin
        $display("FAIL cascade edge %0d: A=%0d B=%0d required A=%0d B=%0d", i, a_out, b_out, ea, eb[0]);
      end else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp;
    do_reset();
    q6.push_back(3'd1); q6.push_back(3'd2); q6.push_back(3'd3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      exp = q6.pop_front();
      total_cnt++;
      if (out6 !== exp) $display("FAIL mid_precount edge %0d: out=%0d required %0d", i, out6, exp);
      else pass_cnt++;
    end
    #1;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (out6 !== 3'd0) $display("FAIL mid_async_clear: out=%0d required 0", out6);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) q6.push_back(3'(i));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      exp = q6.pop_front();
      total_cnt++;
      if (out6 !== exp) $display("FAIL mid_recount edge %0d: out=%0d required %0d", i, out6, exp);
      else pass_cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    #1;
    rst = 1'b1;
    test_reset();
    test_count_n6();
    test_count_n2();
    test_count_n8();
    test_cascade_freeze();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
